bullcow_display: RTL

- Downstream display stage for the Bulls-and-Cows game core on the 8-digit seven-segment panel.
- Captures the game's state code, bull/cow counts and both players' win counters on an update strobe.
- Converts the win counters to BCD with a sequential shift-add-3 engine.
- Time-multiplexes eight digits with mode-dependent content, blinking the winner's score in the end-of-game state.

---
 rtl/bullcow_display.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/bullcow_display.sv
// Seven-segment display stage for the Bulls-and-Cows core: captures game state,
// converts win counters to BCD by double-dabble and scans eight digits.
module bullcow_display #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       update,
  input  logic [2:0] mode,
  input  logic [2:0] bulls,
  input  logic [2:0] cows,
  input  logic [7:0] points_j1,
  input  logic [7:0] points_j2,
  input  logic       winner,
  output logic       busy,
  output logic [7:0] an,
  output logic [7:0] cat
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int FW = $clog2(BLINK_FRAMES + 1);

  localparam logic [7:0] G_J     = 8'hE1;
  localparam logic [7:0] G_B     = 8'h83;
  localparam logic [7:0] G_C     = 8'hC6;
  localparam logic [7:0] G_E     = 8'h86;
  localparam logic [7:0] G_DASH  = 8'hBF;
  localparam logic [7:0] G_BLANK = 8'hFF;

  function automatic logic [7:0] seg(input logic [3:0] d);
    logic [7:0] g;
    case (d)
      4'd0:    g = 8'hC0;
      4'd1:    g = 8'hF9;
      4'd2:    g = 8'hA4;
      4'd3:    g = 8'hB0;
      4'd4:    g = 8'h99;
      4'd5:    g = 8'h92;
      4'd6:    g = 8'h82;
      4'd7:    g = 8'hF8;
      4'd8:    g = 8'h80;
      4'd9:    g = 8'h90;
      default: g = G_BLANK;
    endcase
    return g;
  endfunction

  function automatic logic [7:0] count_glyph(input logic [2:0] v);
    return (v > 3'd4) ? G_E : seg({1'b0, v});
  endfunction

  // One double-dabble step on {bcd[11:0], binary[7:0]}: adjust nibbles, then shift.
  function automatic logic [19:0] dabble(input logic [19:0] s);
    logic [19:0] t;
    t = s;
    for (int n = 0; n < 3; n++) begin
      if (t[8 + 4*n +: 4] >= 4'd5) t[8 + 4*n +: 4] = t[8 + 4*n +: 4] + 4'd3;
    end
    return {t[18:0], 1'b0};
  endfunction

  // Game-state shadows
  logic [2:0] mode_reg, bulls_reg, cows_reg;
  logic       winner_reg;
  logic [2:0] mode_eff, bulls_eff, cows_eff;
  logic       winner_eff;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mode_reg   <= 3'd0;
      bulls_reg  <= 3'd0;
      cows_reg   <= 3'd0;
      winner_reg <= 1'b0;
    end else if (update) begin
      mode_reg   <= mode;
      bulls_reg  <= bulls;
      cows_reg   <= cows;
      winner_reg <= winner;
    end
  end

  // A strobe coinciding with an output update shows the new content on that same edge.
  assign mode_eff   = update ? mode   : mode_reg;
  assign bulls_eff  = update ? bulls  : bulls_reg;
  assign cows_eff   = update ? cows   : cows_reg;
  assign winner_eff = update ? winner : winner_reg;

  // BCD converter, both players in lockstep
  logic [7:0]  points [2];
  logic [19:0] shift_reg [2];
  logic [19:0] shift_next [2];
  logic [11:0] bcd_reg [2];
  logic [2:0]  step_reg;

  assign points[0] = points_j1;
  assign points[1] = points_j2;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy     <= 1'b0;
      step_reg <= 3'd0;
      for (int p = 0; p < 2; p++) begin
        shift_reg[p] <= 20'd0;
        bcd_reg[p]   <= 12'd0;
      end
    end else if (update) begin
      busy     <= 1'b1;
      step_reg <= 3'd0;
      for (int p = 0; p < 2; p++) shift_reg[p] <= {12'd0, points[p]};
    end else if (busy) begin
      step_reg <= step_reg + 3'd1;
      for (int p = 0; p < 2; p++) shift_reg[p] <= shift_next[p];
      if (step_reg == 3'd7) begin
        busy <= 1'b0;
        for (int p = 0; p < 2; p++) bcd_reg[p] <= shift_next[p][19:8];
      end
    end
  end

  // Scan timing
  logic [RW-1:0] refresh_reg;
  logic [2:0]    digit_idx;
  logic [FW-1:0] frame_reg;
  logic          blink_on;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      refresh_reg <= '0;
      digit_idx   <= 3'd0;
      frame_reg   <= '0;
      blink_on    <= 1'b1;
    end else if (refresh_reg == RW'(REFRESH_DIV - 1)) begin
      refresh_reg <= '0;
      digit_idx   <= digit_idx + 3'd1;
      if (digit_idx == 3'd7) begin
        if (frame_reg == FW'(BLINK_FRAMES - 1)) begin
          frame_reg <= '0;
          blink_on  <= ~blink_on;
        end else begin
          frame_reg <= frame_reg + 1'b1;
        end
      end
    end else begin
      refresh_reg <= refresh_reg + 1'b1;
    end
  end

  // Per-player score glyphs {hundreds, tens, ones} with leading-zero and blink blanking
  logic [23:0] score_glyph [2];
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_player
      logic [3:0] hund, tens, ones;
      logic       hidden;
      assign shift_next[gi] = dabble(shift_reg[gi]);
      assign hund   = bcd_reg[gi][11:8];
      assign tens   = bcd_reg[gi][7:4];
      assign ones   = bcd_reg[gi][3:0];
      assign hidden = (winner_eff == 1'(gi)) && !blink_on;
      assign score_glyph[gi] = hidden ? {3{G_BLANK}} :
        {(hund == 4'd0) ? G_BLANK : seg(hund),
         (hund == 4'd0 && tens == 4'd0) ? G_BLANK : seg(tens),
         seg(ones)};
    end
  endgenerate

  logic [7:0] glyph;

  always_comb begin
    glyph = G_DASH;
    case (mode_eff)
      3'b000, 3'b001: begin
        case (digit_idx)
          3'd7:       glyph = G_J;
          3'd6:       glyph = mode_eff[0] ? seg(4'd2) : seg(4'd1);
          3'd5, 3'd4: glyph = G_BLANK;
          default:    glyph = G_DASH;
        endcase
      end
      3'b010, 3'b011: begin
        case (digit_idx)
          3'd7:       glyph = G_J;
          3'd6:       glyph = mode_eff[0] ? seg(4'd2) : seg(4'd1);
          3'd5, 3'd4: glyph = G_BLANK;
          3'd3:       glyph = count_glyph(bulls_eff);
          3'd2:       glyph = G_B;
          3'd1:       glyph = count_glyph(cows_eff);
          default:    glyph = G_C;
        endcase
      end
      3'b111: begin
        case (digit_idx)
          3'd7:       glyph = score_glyph[0][23:16];
          3'd6:       glyph = score_glyph[0][15:8];
          3'd5:       glyph = score_glyph[0][7:0];
          3'd4, 3'd3: glyph = G_BLANK;
          3'd2:       glyph = score_glyph[1][23:16];
          3'd1:       glyph = score_glyph[1][15:8];
          default:    glyph = score_glyph[1][7:0];
        endcase
      end
      default: glyph = G_DASH;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      an  <= 8'hFF;
      cat <= 8'hFF;
    end else begin
      an  <= ~(8'd1 << digit_idx);
      cat <= glyph;
    end
  end

endmodule
